// File: rtl/pipe_stage_hs.sv
// pipe_stage_hs: inter-stage pipeline register with valid/ready handshake, optional 2-entry skid and flush
module pipe_stage_hs #(
  parameter int DW   = 32,
  parameter int RW   = 5,
  parameter int CW   = 3,
  parameter int SKID = 1
) (
  input  logic          clk,
  input  logic          clrn,
  input  logic          flush_i,
  input  logic          in_valid_i,
  output logic          in_ready_o,
  input  logic [CW-1:0] in_ctrl_i,
  input  logic [DW-1:0] in_alu_i,
  input  logic [DW-1:0] in_b_i,
  input  logic [RW-1:0] in_rn_i,
  output logic          out_valid_o,
  input  logic          out_ready_i,
  output logic [CW-1:0] out_ctrl_o,
  output logic [DW-1:0] out_alu_o,
  output logic [DW-1:0] out_b_o,
  output logic [RW-1:0] out_rn_o,
  output logic [1:0]    occ_o
);
  localparam int PW = CW + 2 * DW + RW;
  typedef enum logic [1:0] {ST_EMPTY = 2'd0, ST_FULL = 2'd1, ST_SKID = 2'd2} state_t;
  state_t        state_q, state_d;
  logic [PW-1:0] main_q, main_d, skid_q, skid_d, in_pay;
  logic          accept, emit, ld_main, ld_skid, ld_fwd;
  assign in_pay      = {in_ctrl_i, in_alu_i, in_b_i, in_rn_i};
  // SKID=1 ready comes straight from the state flop; SKID=0 lets a same-cycle emit free the slot
  assign in_ready_o  = (SKID != 0) ? (state_q != ST_SKID) : (out_ready_i | (state_q == ST_EMPTY));
  assign out_valid_o = state_q != ST_EMPTY;
  assign accept      = in_valid_i & in_ready_o;
  assign emit        = out_valid_o & out_ready_i;
  assign occ_o       = state_q;
  assign out_ctrl_o  = out_valid_o ? main_q[PW-1 -: CW] : '0;
  assign out_alu_o   = main_q[2*DW+RW-1 -: DW];
  assign out_b_o     = main_q[DW+RW-1 -: DW];
  assign out_rn_o    = main_q[RW-1:0];
  always_comb begin
    state_d = state_q;
    ld_main = 1'b0;
    ld_skid = 1'b0;
    ld_fwd  = 1'b0;
    case (state_q)
      ST_EMPTY: if (accept) begin
        state_d = ST_FULL;
        ld_main = 1'b1;
      end
      ST_FULL: if (accept && emit) ld_main = 1'b1;
        else if (accept) begin
          state_d = ST_SKID;
          ld_skid = 1'b1;
        end else if (emit) state_d = ST_EMPTY;
      ST_SKID: if (emit) begin
        state_d = ST_FULL;
        ld_fwd  = 1'b1;
      end
      default: state_d = ST_EMPTY;
    endcase
    // flush squashes every entry and the incoming slot but leaves payload regs untouched
    if (flush_i) begin
      state_d = ST_EMPTY;
      ld_main = 1'b0;
      ld_skid = 1'b0;
      ld_fwd  = 1'b0;
    end
    main_d = ld_main ? in_pay : ld_fwd ? skid_q : main_q;
    skid_d = ld_skid ? in_pay : skid_q;
  end
  always_ff @(posedge clk or posedge clrn) begin
    if (clrn) begin
      state_q <= ST_EMPTY;
      main_q  <= '0;
      skid_q  <= '0;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
    end
  end
endmodule

// File: tb/tb_pipe_stage_hs.sv
// tb_pipe_stage_hs: directed checks of pipe_stage_hs with SKID=1 and SKID=0 instances on shared inputs
module tb_pipe_stage_hs;
  logic        clk = 1'b0;
  logic        clrn, flush, in_valid, out_ready;
  logic [2:0]  in_ctrl;
  logic [31:0] in_alu, in_b;
  logic [4:0]  in_rn;
  logic        rdy1, vld1, rdy0, vld0;
  logic [2:0]  ctrl1, ctrl0;
  logic [31:0] alu1, alu0, b1, b0;
  logic [4:0]  rn1, rn0;
  logic [1:0]  occ1, occ0;
  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  pipe_stage_hs #(.SKID(1)) dut (
    .clk(clk), .clrn(clrn), .flush_i(flush), .in_valid_i(in_valid), .in_ready_o(rdy1),
    .in_ctrl_i(in_ctrl), .in_alu_i(in_alu), .in_b_i(in_b), .in_rn_i(in_rn),
    .out_valid_o(vld1), .out_ready_i(out_ready), .out_ctrl_o(ctrl1), .out_alu_o(alu1),
    .out_b_o(b1), .out_rn_o(rn1), .occ_o(occ1));

  pipe_stage_hs #(.SKID(0)) dut0 (
    .clk(clk), .clrn(clrn), .flush_i(flush), .in_valid_i(in_valid), .in_ready_o(rdy0),
    .in_ctrl_i(in_ctrl), .in_alu_i(in_alu), .in_b_i(in_b), .in_rn_i(in_rn),
    .out_valid_o(vld0), .out_ready_i(out_ready), .out_ctrl_o(ctrl0), .out_alu_o(alu0),
    .out_b_o(b0), .out_rn_o(rn0), .occ_o(occ0));

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [31:0] a);
    in_valid = 1'b1;
    in_ctrl  = 3'b001;
    in_alu   = a;
    in_b     = a ^ 32'hFFFF_0000;
    in_rn    = a[4:0];
  endtask

  task automatic test_reset;
    clrn = 1'b1; flush = 1'b0; out_ready = 1'b0;
    in_valid = 1'b1; in_ctrl = 3'b111; in_alu = 32'hDEAD_BEEF; in_b = 32'h1234; in_rn = 5'd7;
    tick; tick;
    n_chk++; if (vld1 !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", vld1); end
    n_chk++; if (ctrl1 !== 3'b000) begin n_fail++; $display("FAIL reset_ctrl: got %b want 000", ctrl1); end
    n_chk++; if (alu1 !== 32'h0) begin n_fail++; $display("FAIL reset_alu: got %h want 0", alu1); end
    n_chk++; if (occ1 !== 2'd0) begin n_fail++; $display("FAIL reset_occ: got %0d want 0", occ1); end
    n_chk++; if (rdy1 !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b want 1", rdy1); end
    n_chk++; if (rdy0 !== 1'b1) begin n_fail++; $display("FAIL reset_ready_skid0: got %b want 1", rdy0); end
    in_valid = 1'b0;
    clrn = 1'b0;
    tick;
  endtask

  task automatic test_streaming;
    out_ready = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      send(i);
      #1;
      n_chk++; if (rdy1 !== 1'b1) begin n_fail++; $display("FAIL stream_ready[%0d]: got %b want 1", i, rdy1); end
      tick;
      n_chk++; if (vld1 !== 1'b1) begin n_fail++; $display("FAIL stream_valid[%0d]: got %b want 1", i, vld1); end
      n_chk++; if (alu1 !== 32'(i)) begin n_fail++; $display("FAIL stream_alu[%0d]: got %h want %h", i, alu1, i); end
      n_chk++; if (ctrl1 !== 3'b001) begin n_fail++; $display("FAIL stream_ctrl[%0d]: got %b want 001", i, ctrl1); end
      n_chk++; if (rn1 !== 5'(i)) begin n_fail++; $display("FAIL stream_rn[%0d]: got %0d want %0d", i, rn1, i); end
    end
    in_valid = 1'b0;
    tick;
    n_chk++; if (vld1 !== 1'b0) begin n_fail++; $display("FAIL stream_drain: got %b want 0", vld1); end
    n_chk++; if (ctrl1 !== 3'b000) begin n_fail++; $display("FAIL stream_bubble_ctrl: got %b want 000", ctrl1); end
  endtask

  task automatic test_backpressure;
    out_ready = 1'b0;
    send(32'hA5);
    tick;
    n_chk++; if (occ1 !== 2'd1) begin n_fail++; $display("FAIL bp_occ1: got %0d want 1", occ1); end
    send(32'h5A);
    tick;
    in_valid = 1'b0;
    n_chk++; if (occ1 !== 2'd2) begin n_fail++; $display("FAIL bp_occ2: got %0d want 2", occ1); end
    n_chk++; if (rdy1 !== 1'b0) begin n_fail++; $display("FAIL bp_ready: got %b want 0", rdy1); end
    n_chk++; if (alu1 !== 32'hA5) begin n_fail++; $display("FAIL bp_head: got %h want a5", alu1); end
    tick;
    n_chk++; if (alu1 !== 32'hA5 || vld1 !== 1'b1 || ctrl1 !== 3'b001) begin n_fail++; $display("FAIL bp_stable: got alu=%h v=%b c=%b want a5/1/001", alu1, vld1, ctrl1); end
    n_chk++; if (b1 !== (32'hA5 ^ 32'hFFFF_0000)) begin n_fail++; $display("FAIL bp_b: got %h want ffff00a5", b1); end
    out_ready = 1'b1;
    tick;
    n_chk++; if (alu1 !== 32'h5A || vld1 !== 1'b1) begin n_fail++; $display("FAIL bp_second: got alu=%h v=%b want 5a/1", alu1, vld1); end
    n_chk++; if (occ1 !== 2'd1) begin n_fail++; $display("FAIL bp_occ_drain1: got %0d want 1", occ1); end
    n_chk++; if (rdy1 !== 1'b1) begin n_fail++; $display("FAIL bp_ready_back: got %b want 1", rdy1); end
    tick;
    n_chk++; if (occ1 !== 2'd0 || vld1 !== 1'b0) begin n_fail++; $display("FAIL bp_empty: got occ=%0d v=%b want 0/0", occ1, vld1); end
  endtask

  task automatic test_flush;
    out_ready = 1'b0;
    send(32'h10);
    tick;
    send(32'h20);
    tick;
    n_chk++; if (occ1 !== 2'd2) begin n_fail++; $display("FAIL flush_pre_occ: got %0d want 2", occ1); end
    flush = 1'b1;
    send(32'h30);
    tick;
    flush = 1'b0; in_valid = 1'b0;
    n_chk++; if (vld1 !== 1'b0) begin n_fail++; $display("FAIL flush_valid: got %b want 0", vld1); end
    n_chk++; if (ctrl1 !== 3'b000) begin n_fail++; $display("FAIL flush_ctrl: got %b want 000", ctrl1); end
    n_chk++; if (occ1 !== 2'd0) begin n_fail++; $display("FAIL flush_occ: got %0d want 0", occ1); end
    n_chk++; if (alu1 !== 32'h10) begin n_fail++; $display("FAIL flush_payload_hold: got %h want 10", alu1); end
    n_chk++; if (vld0 !== 1'b0) begin n_fail++; $display("FAIL flush_valid_skid0: got %b want 0", vld0); end
    out_ready = 1'b1;
    tick;
    n_chk++; if (vld1 !== 1'b0) begin n_fail++; $display("FAIL flush_killed: got %b want 0", vld1); end
    send(32'h40);
    tick;
    in_valid = 1'b0;
    n_chk++; if (alu1 !== 32'h40 || vld1 !== 1'b1) begin n_fail++; $display("FAIL flush_resume: got alu=%h v=%b want 40/1", alu1, vld1); end
    tick;
  endtask

  task automatic test_skid0;
    out_ready = 1'b0;
    send(32'h77);
    #1;
    n_chk++; if (rdy0 !== 1'b1) begin n_fail++; $display("FAIL s0_ready_empty: got %b want 1", rdy0); end
    tick;
    send(32'h88);
    #1;
    n_chk++; if (vld0 !== 1'b1 || alu0 !== 32'h77) begin n_fail++; $display("FAIL s0_hold: got alu=%h v=%b want 77/1", alu0, vld0); end
    n_chk++; if (rdy0 !== 1'b0) begin n_fail++; $display("FAIL s0_ready_blocked: got %b want 0", rdy0); end
    tick;
    n_chk++; if (alu0 !== 32'h77 || occ0 !== 2'd1) begin n_fail++; $display("FAIL s0_stable: got alu=%h occ=%0d want 77/1", alu0, occ0); end
    out_ready = 1'b1;
    #1;
    n_chk++; if (rdy0 !== 1'b1) begin n_fail++; $display("FAIL s0_ready_comb: got %b want 1", rdy0); end
    tick;
    in_valid = 1'b0;
    n_chk++; if (vld0 !== 1'b1 || alu0 !== 32'h88) begin n_fail++; $display("FAIL s0_no_bubble: got alu=%h v=%b want 88/1", alu0, vld0); end
    tick;
    n_chk++; if (vld0 !== 1'b0 || occ0 !== 2'd0) begin n_fail++; $display("FAIL s0_drain: got v=%b occ=%0d want 0/0", vld0, occ0); end
    tick;
  endtask

  task automatic test_async_reset;
    out_ready = 1'b1; in_valid = 1'b0;
    tick; tick;
    out_ready = 1'b0;
    send(32'h21);
    tick;
    send(32'h22);
    tick;
    in_valid = 1'b0;
    n_chk++; if (occ1 !== 2'd2) begin n_fail++; $display("FAIL ar_pre_occ: got %0d want 2", occ1); end
    #2 clrn = 1'b1;
    #1;
    n_chk++; if (vld1 !== 1'b0 || occ1 !== 2'd0) begin n_fail++; $display("FAIL ar_clear: got v=%b occ=%0d want 0/0", vld1, occ1); end
    n_chk++; if (alu1 !== 32'h0 || ctrl1 !== 3'b000) begin n_fail++; $display("FAIL ar_zero: got alu=%h c=%b want 0/000", alu1, ctrl1); end
    #1 clrn = 1'b0;
    tick;
    out_ready = 1'b1;
    send(32'h11);
    tick;
    in_valid = 1'b0;
    n_chk++; if (vld1 !== 1'b1 || alu1 !== 32'h11) begin n_fail++; $display("FAIL ar_resume: got alu=%h v=%b want 11/1", alu1, vld1); end
    tick;
  endtask

  initial begin
    #200000;
    n_fail++;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset;
    test_streaming;
    test_backpressure;
    test_flush;
    test_skid0;
    test_async_reset;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
